// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and helpers for the BTB/BHT branch predictor:
//               2-bit direction counter, saturating update functions and
//               index-mode selectors.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Index mode selectors for the MODE parameter
  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Direction counter: strong/weak not-taken, weak/strong taken
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Move one step towards strong taken, sticking at ST
  function automatic ctr_e sat_inc(input ctr_e c);
    ctr_e r;
    case (c)
      SNT:     r = WNT;
      WNT:     r = WT;
      default: r = ST;
    endcase
    return r;
  endfunction

  // Move one step towards strong not-taken, sticking at SNT
  function automatic ctr_e sat_dec(input ctr_e c);
    ctr_e r;
    case (c)
      ST:      r = WT;
      WT:      r = WNT;
      default: r = SNT;
    endcase
    return r;
  endfunction

  // The table entry record {valid, tag, target, ctr} is declared inside
  // bp_table because its tag and target widths follow that module's
  // parameters.

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_table.sv
`default_nettype none
// ============================================================================
// Module      : bp_table
// Description : Direct-mapped predictor storage. Two combinational read
//               ports (fetch lookup, resolve-side read-modify-write), one
//               write port, and a synchronous clear of all valid bits while
//               rst is low.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24,
  parameter int PC_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch-side lookup
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [PC_W-1:0]       rd_target,
  output ctr_e                  rd_ctr,
  // resolve-side read of the entry about to be updated
  input  logic [INDEX_BITS-1:0] up_idx,
  output logic                  up_valid,
  output logic [TAG_BITS-1:0]   up_tag,
  output logic [PC_W-1:0]       up_target,
  output ctr_e                  up_ctr,
  // write port
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_valid,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [PC_W-1:0]       wr_target,
  input  ctr_e                  wr_ctr
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_W-1:0]     target;
    ctr_e                ctr;
  } entry_t;

  entry_t mem_q [ENTRIES];
  entry_t mem_d [ENTRIES];

  // Next table state: clear wins over write; only valid bits need clearing
  always_comb begin
    mem_d = mem_q;
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_d[i].valid = 1'b0;
      end
    end else if (wr_en) begin
      mem_d[wr_idx] = '{valid: wr_valid, tag: wr_tag, target: wr_target, ctr: wr_ctr};
    end
  end

  // Table storage register
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_valid  = mem_q[rd_idx].valid;
  assign rd_tag    = mem_q[rd_idx].tag;
  assign rd_target = mem_q[rd_idx].target;
  assign rd_ctr    = mem_q[rd_idx].ctr;

  assign up_valid  = mem_q[up_idx].valid;
  assign up_tag    = mem_q[up_idx].tag;
  assign up_target = mem_q[up_idx].target;
  assign up_ctr    = mem_q[up_idx].ctr;

endmodule : bp_table
`default_nettype wire

// File: rtl/bp_btb_bht.sv
`default_nettype none
// ============================================================================
// Module      : bp_btb_bht
// Description : Combined BTB/BHT branch predictor. Zero-latency lookup in IF,
//               resolution in ID with refetch/redirect, wrong-path squash,
//               optional gshare indexing with a speculative global history,
//               and saturating prediction statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_btb_bht
  import bp_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int INDEX_BITS = 6,
  parameter int INST_BYTES = 4,
  parameter int MODE       = 0,
  parameter int GHR_BITS   = 6,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  // fetch
  input  logic [PC_W-1:0]  pc_if,
  output logic             hit_if,
  output logic             taken_if,
  output logic [PC_W-1:0]  pred_pc_if,
  // pipeline control / resolve
  input  logic             fd_stall,
  input  logic             inst_valid_id,
  input  logic             is_branch_id,
  input  logic             branch_taken_id,
  input  logic [PC_W-1:0]  pc_id,
  input  logic [PC_W-1:0]  target_id,
  output logic             refetch,
  output logic [PC_W-1:0]  redirect_pc,
  // statistics
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int ALIGN    = $clog2(INST_BYTES);
  localparam int TAG_BITS = PC_W - INDEX_BITS - ALIGN;

  // IF/ID pipeline state, global history and statistics
  logic                  taken_id_q,   taken_id_d;
  logic [PC_W-1:0]       pred_pc_id_q, pred_pc_id_d;
  logic                  hit_id_q,     hit_id_d;
  logic [INDEX_BITS-1:0] idx_id_q,     idx_id_d;
  logic [GHR_BITS-1:0]   ghr_snap_q,   ghr_snap_d;
  logic                  squash_q,     squash_d;
  logic [GHR_BITS-1:0]   ghr_q,        ghr_d;
  logic [CNT_W-1:0]      branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]      mispred_cnt_q, mispred_cnt_d;

  // table ports
  logic [INDEX_BITS-1:0] idx_if;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [PC_W-1:0]       rd_target;
  ctr_e                  rd_ctr;
  logic                  up_valid;
  logic [TAG_BITS-1:0]   up_tag;
  logic [PC_W-1:0]       up_target;
  ctr_e                  up_ctr;
  logic                  wr_en;
  logic                  wr_valid;
  logic [TAG_BITS-1:0]   wr_tag;
  logic [PC_W-1:0]       wr_target;
  ctr_e                  wr_ctr;

  logic                  lookup_hit;
  logic                  act;
  logic                  mispredict;

  // --------------------------------------------------------------------------
  // IF lookup
  // --------------------------------------------------------------------------
  assign idx_if = pc_if[ALIGN +: INDEX_BITS]
                ^ ((MODE == MODE_GSHARE) ? INDEX_BITS'(ghr_q) : '0);

  bp_table #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .PC_W       (PC_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx_if),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_ctr    (rd_ctr),
    .up_idx    (idx_id_q),
    .up_valid  (up_valid),
    .up_tag    (up_tag),
    .up_target (up_target),
    .up_ctr    (up_ctr),
    .wr_en     (wr_en),
    .wr_idx    (idx_id_q),
    .wr_valid  (wr_valid),
    .wr_tag    (wr_tag),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  assign lookup_hit = rd_valid && (rd_tag == pc_if[PC_W-1 -: TAG_BITS]);
  assign hit_if     = rst & lookup_hit;
  assign taken_if   = hit_if & ((rd_ctr == WT) || (rd_ctr == ST));
  assign pred_pc_if = hit_if ? rd_target : '0;

  // Instruction-alignment bits of the fetch PC never reach the table
  generate
    if (ALIGN > 0) begin : g_align
      logic unused_align_bits;
      assign unused_align_bits = ^pc_if[ALIGN-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // ID resolve
  // --------------------------------------------------------------------------
  assign act = rst & inst_valid_id & ~squash_q & ~fd_stall;

  assign mispredict = is_branch_id
                    ? ((branch_taken_id != taken_id_q) ||
                       (branch_taken_id && taken_id_q && (pred_pc_id_q != target_id)))
                    : taken_id_q;

  assign refetch     = act & mispredict;
  assign redirect_pc = !rst ? '0
                     : (is_branch_id && branch_taken_id) ? target_id
                     : pc_id + PC_W'(INST_BYTES);

  // Table update for the resolving slot, at the index it was looked up with
  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = up_valid;
    wr_tag    = up_tag;
    wr_target = up_target;
    wr_ctr    = up_ctr;
    if (act) begin
      if (is_branch_id) begin
        if (branch_taken_id) begin
          wr_en     = 1'b1;
          wr_valid  = 1'b1;
          wr_tag    = pc_id[PC_W-1 -: TAG_BITS];
          wr_target = target_id;
          wr_ctr    = hit_id_q ? sat_inc(up_ctr) : WT;
        end else if (hit_id_q) begin
          wr_en  = 1'b1;
          wr_ctr = sat_dec(up_ctr);
        end
      end else if (hit_id_q) begin
        // a non-branch matched an entry: it aliases, so kill it
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  // IF/ID load/hold; the slot fetched alongside a refetch is wrong-path
  always_comb begin
    taken_id_d   = taken_id_q;
    pred_pc_id_d = pred_pc_id_q;
    hit_id_d     = hit_id_q;
    idx_id_d     = idx_id_q;
    ghr_snap_d   = ghr_snap_q;
    squash_d     = squash_q;
    if (!fd_stall) begin
      taken_id_d   = taken_if;
      pred_pc_id_d = pred_pc_if;
      hit_id_d     = hit_if;
      idx_id_d     = idx_if;
      ghr_snap_d   = ghr_q;
      squash_d     = refetch;
    end
  end

  // Global history: restore on refetch beats the speculative shift
  always_comb begin
    ghr_d = ghr_q;
    if (MODE == MODE_GSHARE) begin
      if (refetch) begin
        ghr_d = is_branch_id ? GHR_BITS'({ghr_snap_q, branch_taken_id}) : ghr_snap_q;
      end else if (hit_if && !fd_stall) begin
        ghr_d = GHR_BITS'({ghr_q, taken_if});
      end
    end
  end

  // Saturating statistics counters
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (act && is_branch_id && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (refetch && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      taken_id_q    <= 1'b0;
      pred_pc_id_q  <= '0;
      hit_id_q      <= 1'b0;
      idx_id_q      <= '0;
      ghr_snap_q    <= '0;
      squash_q      <= 1'b0;
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      taken_id_q    <= taken_id_d;
      pred_pc_id_q  <= pred_pc_id_d;
      hit_id_q      <= hit_id_d;
      idx_id_q      <= idx_id_d;
      ghr_snap_q    <= ghr_snap_d;
      squash_q      <= squash_d;
      ghr_q         <= ghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule : bp_btb_bht
`default_nettype wire

// File: tb/tb_bp_btb_bht.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_btb_bht
// Description : Directed self-checking bench for bp_btb_bht. One bimodal and
//               one gshare instance share the stimulus; each phase checks the
//               instance it targets against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_btb_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        fd_stall;
  logic        inst_valid_id;
  logic        is_branch_id;
  logic        branch_taken_id;
  logic [31:0] pc_id;
  logic [31:0] target_id;

  logic        hit0, taken0, refetch0;
  logic [31:0] pred0, redir0;
  logic [15:0] bcnt0, mcnt0;
  logic        hit1, taken1, refetch1;
  logic [31:0] pred1, redir1;
  logic [15:0] bcnt1, mcnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_btb_bht #(.MODE(0)) u_dut0 (
    .clk (clk), .rst (rst), .pc_if (pc_if),
    .hit_if (hit0), .taken_if (taken0), .pred_pc_if (pred0),
    .fd_stall (fd_stall), .inst_valid_id (inst_valid_id), .is_branch_id (is_branch_id),
    .branch_taken_id (branch_taken_id), .pc_id (pc_id), .target_id (target_id),
    .refetch (refetch0), .redirect_pc (redir0),
    .branch_cnt (bcnt0), .mispred_cnt (mcnt0)
  );

  bp_btb_bht #(.MODE(1)) u_dut1 (
    .clk (clk), .rst (rst), .pc_if (pc_if),
    .hit_if (hit1), .taken_if (taken1), .pred_pc_if (pred1),
    .fd_stall (fd_stall), .inst_valid_id (inst_valid_id), .is_branch_id (is_branch_id),
    .branch_taken_id (branch_taken_id), .pc_id (pc_id), .target_id (target_id),
    .refetch (refetch1), .redirect_pc (redir1),
    .branch_cnt (bcnt1), .mispred_cnt (mcnt1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic id_idle();
    inst_valid_id   = 1'b0;
    is_branch_id    = 1'b0;
    branch_taken_id = 1'b0;
    pc_id           = 32'h0;
    target_id       = 32'h0;
  endtask

  task automatic id_br(input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
    inst_valid_id   = 1'b1;
    is_branch_id    = 1'b1;
    branch_taken_id = tk;
    pc_id           = pc;
    target_id       = tgt;
  endtask

  initial begin
    // ---------------- reset: outputs forced low ----------------
    rst = 1'b0; fd_stall = 1'b0; pc_if = 32'h40;
    id_br(1'b1, 32'h40, 32'h100);
    settle();
    check("rst_hit", hit0, 0);
    check("rst_refetch", refetch0, 0);
    check("rst_redirect", redir0, 0);
    step(); step();
    rst = 1'b1; id_idle();
    settle();
    check("rst_bcnt", bcnt0, 0);
    check("rst_mcnt", mcnt0, 0);

    // ---------------- bimodal: allocate 0x40 -> 0x100 ----------------
    pc_if = 32'h40; settle();
    check("c1_hit", hit0, 0);
    check("c1_pred", pred0, 0);
    step();
    id_br(1'b1, 32'h40, 32'h100); pc_if = 32'h44; settle();
    check("c2_refetch", refetch0, 1);
    check("c2_redirect", redir0, 32'h100);
    step();
    check("c2_bcnt", bcnt0, 1);
    check("c2_mcnt", mcnt0, 1);
    id_idle(); pc_if = 32'h40; settle();
    check("c3_hit", hit0, 1);
    check("c3_taken", taken0, 1);
    check("c3_pred", pred0, 32'h100);
    step();

    // ---------------- two not-taken resolutions ----------------
    id_br(1'b0, 32'h40, 32'h100); pc_if = 32'h100; settle();
    check("c4_refetch", refetch0, 1);
    check("c4_redirect", redir0, 32'h44);
    step();
    id_idle(); pc_if = 32'h40; settle();
    check("c5_hit", hit0, 1);
    check("c5_taken_wnt", taken0, 0);
    step();
    id_br(1'b0, 32'h40, 32'h100); pc_if = 32'h44; settle();
    check("c6_refetch", refetch0, 0);
    step();
    check("c6_bcnt", bcnt0, 3);
    check("c6_mcnt", mcnt0, 2);
    id_idle(); pc_if = 32'h40; settle();
    check("c7_hit", hit0, 1);
    check("c7_taken_snt", taken0, 0);
    step();

    // ---------------- alias replacement 0x1040 -> 0x200 ----------------
    pc_if = 32'h1040; settle();
    check("c8_alias_miss", hit0, 0);
    step();
    id_br(1'b1, 32'h1040, 32'h200); pc_if = 32'h1044; settle();
    check("c9_refetch", refetch0, 1);
    check("c9_redirect", redir0, 32'h200);
    step();
    id_idle(); pc_if = 32'h40; settle();
    check("c10_old_miss", hit0, 0);
    step();
    pc_if = 32'h1040; settle();
    check("c11_hit", hit0, 1);
    check("c11_taken", taken0, 1);
    check("c11_pred", pred0, 32'h200);
    step();

    // ---------------- mispredict held by a 3-cycle stall ----------------
    id_br(1'b0, 32'h1040, 32'h200); pc_if = 32'h1044; fd_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_refetch", refetch0, 0);
      step();
    end
    check("stall_bcnt", bcnt0, 4);
    check("stall_mcnt", mcnt0, 3);
    fd_stall = 1'b0; settle();
    check("c15_refetch", refetch0, 1);
    check("c15_redirect", redir0, 32'h1044);
    step();
    pc_if = 32'h80; settle();
    check("c16_pulse_end", refetch0, 0);
    check("c16_hit", hit0, 0);
    step();
    check("c16_bcnt", bcnt0, 5);
    check("c16_mcnt", mcnt0, 4);

    // ---------------- squash of a predicted-taken wrong-path slot ----------------
    id_br(1'b1, 32'h80, 32'h300); pc_if = 32'h84; settle();
    check("c17_refetch", refetch0, 1);
    step();
    id_idle(); pc_if = 32'h300; settle();
    check("c18_hit", hit0, 0);
    step();
    id_br(1'b1, 32'h300, 32'h500); pc_if = 32'h80; settle();
    check("c19_hit", hit0, 1);
    check("c19_pred", pred0, 32'h300);
    check("c19_refetch", refetch0, 1);
    check("c19_redirect", redir0, 32'h500);
    step();
    id_br(1'b0, 32'h80, 32'h300); pc_if = 32'h84; settle();
    check("c20_squash_refetch", refetch0, 0);
    step();
    check("c20_bcnt", bcnt0, 7);
    check("c20_mcnt", mcnt0, 6);
    id_idle(); pc_if = 32'h80; settle();
    check("c21_taken_kept", taken0, 1);
    check("c21_pred_kept", pred0, 32'h300);
    step();

    // ---------------- one-cycle reset mid-run ----------------
    rst = 1'b0; settle();
    check("r2_forced_hit", hit0, 0);
    check("r2_forced_pred", pred0, 0);
    step();
    rst = 1'b1; settle();
    check("r2_hit_after", hit0, 0);
    check("r2_bcnt", bcnt0, 0);
    check("r2_mcnt", mcnt0, 0);

    // ---------------- gshare instance ----------------
    pc_if = 32'h40; settle();
    check("s1_hit", hit1, 0);
    step();
    id_br(1'b1, 32'h40, 32'h100); pc_if = 32'h44; settle();
    check("s2_refetch", refetch1, 1);
    step();
    check("s2_ghr", u_dut1.ghr_q, 6'd1);
    id_idle(); pc_if = 32'h48; settle();
    check("s3_hit", hit1, 0);
    step();
    id_br(1'b1, 32'h48, 32'h200); pc_if = 32'h4C; settle();
    check("s4_refetch", refetch1, 1);
    check("s4_redirect", redir1, 32'h200);
    step();
    check("s4_ghr", u_dut1.ghr_q, 6'd3);
    id_idle(); pc_if = 32'h4C; settle();
    check("s5_hit", hit1, 1);
    check("s5_pred", pred1, 32'h100);
    step();
    check("s5_ghr", u_dut1.ghr_q, 6'd7);
    id_br(1'b1, 32'h4C, 32'h104); pc_if = 32'h50; settle();
    check("s6_hit", hit1, 1);
    check("s6_pred", pred1, 32'h200);
    check("s6_refetch", refetch1, 1);
    check("s6_redirect", redir1, 32'h104);
    step();
    check("s6_ghr_restore", u_dut1.ghr_q, 6'd7);
    id_idle(); pc_if = 32'h50; settle();
    check("s7_taken", taken1, 1);
    step();
    check("s7_ghr_shift", u_dut1.ghr_q, 6'd15);
    pc_if = 32'h7C; settle();
    check("s8_pred_new", pred1, 32'h104);
    check("s8_bcnt", bcnt1, 3);
    check("s8_mcnt", mcnt1, 3);
    step();

    // ---------------- reset clears gshare state ----------------
    rst = 1'b0; pc_if = 32'h7C; settle();
    check("r3_forced_hit", hit1, 0);
    step();
    rst = 1'b1; pc_if = 32'h40; settle();
    check("r3_hit", hit1, 0);
    check("r3_ghr", u_dut1.ghr_q, 6'd0);
    check("r3_bcnt", bcnt1, 0);
    check("r3_mcnt", mcnt1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bp_btb_bht
`default_nettype wire
